// File: rtl/aes_inv_key_sched_if.sv
// Handshake/bus bundle for the AES-128 inverse key scheduler.
//   key_load  : 1-cycle pulse, capture key_in and start forward expansion
//   key_in    : 128-bit cipher key, word0 = bits [127:96]
//   busy      : forward expansion in progress
//   key_ready : round-10 key stored, backward walk may start
//   rk_start  : begin/restart backward walk at round 10
//   rk_next   : advance to next lower round key
//   rk_out    : current round key
//   rk_round  : round index of rk_out (10..0)
//   rk_valid  : rk_out/rk_round valid
//   rk_last   : rk_valid and rk_round == 0
// slave = the scheduler, master = its user (decryption datapath / bench).
interface aes_inv_key_sched_if;
  logic         key_load;
  logic [127:0] key_in;
  logic         busy;
  logic         key_ready;
  logic         rk_start;
  logic         rk_next;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_last;

  modport slave (
    input  key_load, key_in, rk_start, rk_next,
    output busy, key_ready, rk_out, rk_round, rk_valid, rk_last
  );

  modport master (
    output key_load, key_in, rk_start, rk_next,
    input  busy, key_ready, rk_out, rk_round, rk_valid, rk_last
  );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 decryption key scheduler.
// A key_load runs the forward key expansion for 10 cycles and keeps the
// round-10 key. Each rk_start/rk_next then walks backward one round per
// handshake, presenting round keys 10 down to 0. One 32-bit SubWord block
// is shared by the forward and inverse rounds.
// Ports:
//   clk : clock, all state updates on rising edge
//   rst : synchronous active-high reset
//   bus : aes_inv_key_sched_if.slave (key load, status, round-key walk)
module aes_inv_key_sched (
  input  logic                clk,
  input  logic                rst,
  aes_inv_key_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2,
    WALK   = 2'd3
  } state_t;

  // AES S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;
  localparam logic [3:0] LAST_ROUND = 4'd10;
  localparam logic [3:0] LAST_CNT   = 4'd9;

  // Entry x sits at bit offset (255-x)*8, and 255-x == ~x for a byte.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse of xtime: undo the conditional 0x1b reduction, then shift back.
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    logic [7:0] y;
    y = x ^ 8'h1b;
    inv_xtime = x[0] ? ({1'b0, y[7:1]} | 8'h80) : {1'b0, x[7:1]};
  endfunction

  state_t       state_reg, state_next;
  logic [127:0] key_reg, key_next;
  logic [127:0] stored_reg, stored_next;
  logic [7:0]   rcon_reg, rcon_next;
  logic [3:0]   round_reg, round_next;
  logic [3:0]   cnt_reg, cnt_next;

  // Current round key split into words, word0 most significant.
  logic [31:0] w0, w1, w2, w3;
  assign w0 = key_reg[127:96];
  assign w1 = key_reg[95:64];
  assign w2 = key_reg[63:32];
  assign w3 = key_reg[31:0];

  // Inverse round recovers the previous w3 first (w3 ^ w2); that value
  // feeds SubWord to rebuild w0. Forward round uses w3 directly.
  logic [31:0] inv_w3;
  logic [31:0] sub_in;
  logic [31:0] rot_word;
  logic [31:0] sub_word;
  logic [31:0] t_word;

  assign inv_w3   = w3 ^ w2;
  assign sub_in   = (state_reg == WALK) ? inv_w3 : w3;
  assign rot_word = {sub_in[23:0], sub_in[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
    end
  endgenerate

  assign t_word = sub_word ^ {rcon_reg, 24'h000000};

  // Forward round: chain of XORs from the new w0.
  logic [31:0] fw0, fw1, fw2, fw3;
  assign fw0 = w0 ^ t_word;
  assign fw1 = w1 ^ fw0;
  assign fw2 = w2 ^ fw1;
  assign fw3 = w3 ^ fw2;

  // Inverse round: peel XORs from the top, w0 last.
  logic [127:0] fwd_key;
  logic [127:0] inv_key;
  assign fwd_key = {fw0, fw1, fw2, fw3};
  assign inv_key = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, inv_w3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      key_reg    <= '0;
      stored_reg <= '0;
      rcon_reg   <= '0;
      round_reg  <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      key_reg    <= key_next;
      stored_reg <= stored_next;
      rcon_reg   <= rcon_next;
      round_reg  <= round_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    key_next    = key_reg;
    stored_next = stored_reg;
    rcon_next   = rcon_reg;
    round_next  = round_reg;
    cnt_next    = cnt_reg;

    if (bus.key_load) begin
      key_next   = bus.key_in;
      rcon_next  = RCON_FIRST;
      cnt_next   = '0;
      state_next = EXPAND;
    end else begin
      unique case (state_reg)
        IDLE: begin
        end

        EXPAND: begin
          key_next  = fwd_key;
          rcon_next = xtime(rcon_reg);
          cnt_next  = cnt_reg + 4'd1;
          if (cnt_reg == LAST_CNT) begin
            stored_next = fwd_key;
            state_next  = READY;
          end
        end

        READY: begin
          if (bus.rk_start) begin
            key_next   = stored_reg;
            round_next = LAST_ROUND;
            rcon_next  = RCON_LAST;
            state_next = WALK;
          end
        end

        WALK: begin
          if (bus.rk_start) begin
            key_next   = stored_reg;
            round_next = LAST_ROUND;
            rcon_next  = RCON_LAST;
          end else if (bus.rk_next) begin
            if (round_reg == 4'd0) begin
              // Walk finished: rk_out keeps the round-0 key.
              state_next = READY;
            end else begin
              key_next   = inv_key;
              round_next = round_reg - 4'd1;
              rcon_next  = inv_xtime(rcon_reg);
            end
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_reg == EXPAND);
  assign bus.key_ready = (state_reg == READY) || (state_reg == WALK);
  assign bus.rk_valid  = (state_reg == WALK);
  assign bus.rk_last   = (state_reg == WALK) && (round_reg == 4'd0);
  assign bus.rk_out    = key_reg;
  assign bus.rk_round  = round_reg;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
module tb_aes_inv_key_sched;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  aes_inv_key_sched_if bus ();

  aes_inv_key_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_next();
    bus.rk_next = 1'b1;
    tick();
    bus.rk_next = 1'b0;
  endtask

  task automatic pulse_start();
    bus.rk_start = 1'b1;
    tick();
    bus.rk_start = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    bus.key_in   = k;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.key_load = 1'b0;
    bus.key_in   = '0;
    bus.rk_start = 1'b0;
    bus.rk_next  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_key_ready", bus.key_ready, 0);
    chk("rst_rk_valid", bus.rk_valid, 0);
    chk("rst_rk_last", bus.rk_last, 0);
    chk("rst_rk_out", bus.rk_out, 0);
    chk("rst_rk_round", bus.rk_round, 0);
    $display("reset checked");

    // 1: forward expansion of FIPS-197 key
    load_key(K);
    chk("exp_busy_e0", bus.busy, 1);
    chk("exp_ready_e0", bus.key_ready, 0);
    for (int i = 1; i < 10; i++) begin
      tick();
      chk($sformatf("exp_busy_e%0d", i), bus.busy, 1);
      chk($sformatf("exp_ready_e%0d", i), bus.key_ready, 0);
    end
    tick();
    chk("exp_busy_e10", bus.busy, 0);
    chk("exp_ready_e10", bus.key_ready, 1);
    $display("key_load K: expansion done, key_ready=%0b", bus.key_ready);

    pulse_start();
    chk("start_rk_out", bus.rk_out, R10);
    chk("start_round", bus.rk_round, 10);
    chk("start_valid", bus.rk_valid, 1);
    chk("start_last", bus.rk_last, 0);
    $display("rk_start: round=%0d rk=%h", bus.rk_round, bus.rk_out);

    // 2: full backward walk
    pulse_next();
    chk("walk_r9_out", bus.rk_out, R9);
    chk("walk_r9_round", bus.rk_round, 9);
    for (int r = 8; r >= 1; r--) begin
      pulse_next();
      chk($sformatf("walk_round_%0d", r), bus.rk_round, r);
      if (r == 5) chk("walk_r5_out", bus.rk_out, R5);
      $display("rk_next: round=%0d rk=%h", bus.rk_round, bus.rk_out);
    end
    chk("walk_r1_out", bus.rk_out, R1);
    chk("walk_r1_last", bus.rk_last, 0);
    pulse_next();
    chk("walk_r0_out", bus.rk_out, K);
    chk("walk_r0_round", bus.rk_round, 0);
    chk("walk_r0_last", bus.rk_last, 1);
    chk("walk_r0_valid", bus.rk_valid, 1);
    pulse_next();
    chk("walk_end_valid", bus.rk_valid, 0);
    chk("walk_end_last", bus.rk_last, 0);
    chk("walk_end_hold", bus.rk_out, K);
    chk("walk_end_ready", bus.key_ready, 1);
    $display("walk end: rk_valid=%0b rk=%h", bus.rk_valid, bus.rk_out);

    // 6a: rk_next in READY is ignored
    pulse_next();
    chk("ready_next_valid", bus.rk_valid, 0);
    chk("ready_next_out", bus.rk_out, K);
    chk("ready_next_round", bus.rk_round, 0);

    // 3: restart mid-walk, and start+next together
    pulse_start();
    for (int i = 0; i < 5; i++) pulse_next();
    chk("mid_r5_round", bus.rk_round, 5);
    chk("mid_r5_out", bus.rk_out, R5);
    pulse_start();
    chk("restart_round", bus.rk_round, 10);
    chk("restart_out", bus.rk_out, R10);
    pulse_next();
    pulse_next();
    chk("pre_both_round", bus.rk_round, 8);
    bus.rk_start = 1'b1;
    bus.rk_next  = 1'b1;
    tick();
    bus.rk_start = 1'b0;
    bus.rk_next  = 1'b0;
    chk("both_round", bus.rk_round, 10);
    chk("both_out", bus.rk_out, R10);
    $display("start+next: round=%0d rk=%h", bus.rk_round, bus.rk_out);

    // 4: zero key loaded mid-walk
    pulse_next();
    chk("z_pre_round", bus.rk_round, 9);
    load_key('0);
    chk("z_abort_valid", bus.rk_valid, 0);
    chk("z_abort_busy", bus.busy, 1);
    chk("z_abort_ready", bus.key_ready, 0);
    for (int i = 1; i < 10; i++) tick();
    chk("z_e9_ready", bus.key_ready, 0);
    tick();
    chk("z_e10_ready", bus.key_ready, 1);
    chk("z_e10_busy", bus.busy, 0);
    pulse_start();
    chk("z_r10_out", bus.rk_out, Z10);
    chk("z_r10_round", bus.rk_round, 10);
    for (int i = 0; i < 9; i++) pulse_next();
    chk("z_r1_out", bus.rk_out, Z1);
    pulse_next();
    chk("z_r0_out", bus.rk_out, 0);
    chk("z_r0_round", bus.rk_round, 0);
    chk("z_r0_last", bus.rk_last, 1);
    $display("zero key walk: round=%0d rk=%h", bus.rk_round, bus.rk_out);

    // 5: reset during EXPAND
    load_key(K);
    for (int i = 0; i < 4; i++) tick();
    chk("rst_mid_busy_pre", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_ready", bus.key_ready, 0);
    chk("rst_mid_valid", bus.rk_valid, 0);
    chk("rst_mid_last", bus.rk_last, 0);
    chk("rst_mid_out", bus.rk_out, 0);
    chk("rst_mid_round", bus.rk_round, 0);
    pulse_start();
    chk("idle_start_valid", bus.rk_valid, 0);
    chk("idle_start_out", bus.rk_out, 0);
    // 6b: rk_next in IDLE is ignored
    pulse_next();
    chk("idle_next_valid", bus.rk_valid, 0);
    chk("idle_next_round", bus.rk_round, 0);
    chk("idle_next_out", bus.rk_out, 0);
    $display("reset mid-expand: busy=%0b rk_valid=%0b", bus.busy, bus.rk_valid);

    // rk_start during EXPAND is ignored; READY keeps round-10 key on rk_out
    load_key(K);
    pulse_start();
    chk("exp_start_valid", bus.rk_valid, 0);
    chk("exp_start_busy", bus.busy, 1);
    for (int i = 2; i < 10; i++) tick();
    tick();
    chk("reload_ready", bus.key_ready, 1);
    pulse_next();
    chk("ready2_next_valid", bus.rk_valid, 0);
    chk("ready2_next_round", bus.rk_round, 0);
    chk("ready2_next_out", bus.rk_out, R10);
    $display("reload: key_ready=%0b rk=%h", bus.key_ready, bus.rk_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
